// File: rtl/mult_div_pkg.sv
// Shared types and constants for the iterative multiply/divide engine.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mult_div_pkg;

   // Default operand width; HI and LO are each this wide.
   localparam int DEFAULT_WIDTH = 32;

   // Every quotient bit is set when the divisor is zero.
   localparam logic DIV0_Q_BIT = 1'b1;
   localparam logic [DEFAULT_WIDTH-1:0] DIV0_QUOTIENT = {DEFAULT_WIDTH{DIV0_Q_BIT}};

   // Sequencer states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      FIX  = 2'd3
   } state_t;

endpackage

// File: rtl/mult_div_unit_twos_comp_abs.sv
// Conditional two's-complement negate; gives magnitudes and re-applies result signs.
// Latency: purely combinational.
// Backpressure: none.
module twos_comp_abs #(
   parameter int W = 32
) (
   input  logic [W-1:0] value,
   input  logic         negate,
   output logic [W-1:0] result
);

   // Invert-and-increment when negate is set; the most negative value maps to itself,
   // which is the correct unsigned magnitude.
   always_comb begin
      result = negate ? (~value + {{(W-1){1'b0}}, 1'b1}) : value;
   end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (shift-add) / divide (restoring) engine; optional div_zero flag under MULT_DIV_DIV0_FLAG_EN.
// Latency: start accepted at edge E0, done pulses after edge E(WIDTH+1); divide by zero after E2.
// Backpressure: starts arriving while busy are ignored; done is a one-cycle pulse with no ready.
module mult_div_unit
   import mult_div_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             mult_start,
   input  logic             div_start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             mult_done,
   output logic             div_done,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
`ifdef MULT_DIV_DIV0_FLAG_EN
   ,
   output logic             div_zero
`endif
);

   localparam int CW = $clog2(WIDTH);

   state_t             state;
   logic [2*WIDTH-1:0] acc;      // mult: {partial product, multiplier}; div: {remainder, quotient}
   logic [WIDTH-1:0]   opnd;     // multiplicand or divisor magnitude
   logic [CW-1:0]      cnt;
   logic               is_mul;
   logic               res_neg;  // product / quotient sign
   logic               dvd_neg;  // remainder follows the dividend sign
   logic               div0;

   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

   logic [WIDTH:0]     mul_sum, div_sh, div_diff;
   logic [2*WIDTH-1:0] mul_next, div_next;

   twos_comp_abs #(.W(WIDTH))   u_abs_a (.value(op_a), .negate(op_a[WIDTH-1]), .result(mag_a));
   twos_comp_abs #(.W(WIDTH))   u_abs_b (.value(op_b), .negate(op_b[WIDTH-1]), .result(mag_b));
   twos_comp_abs #(.W(2*WIDTH)) u_fix_p (.value(acc), .negate(res_neg), .result(prod_fix));
   twos_comp_abs #(.W(WIDTH))   u_fix_q (.value(acc[WIDTH-1:0]), .negate(res_neg & ~div0), .result(quo_fix));
   twos_comp_abs #(.W(WIDTH))   u_fix_r (.value(acc[2*WIDTH-1:WIDTH]), .negate(dvd_neg), .result(rem_fix));

   // One iteration of each algorithm, computed from the current accumulator.
   always_comb begin
      mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
      mul_next = {mul_sum, acc[WIDTH-1:1]};
      div_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      div_diff = div_sh - {1'b0, opnd};
      if (div_diff[WIDTH]) begin
         div_next = {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end else begin
         div_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end
   end

   // Sequencer with registered results, done pulses and busy.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         acc       <= '0;
         opnd      <= '0;
         cnt       <= '0;
         is_mul    <= 1'b0;
         res_neg   <= 1'b0;
         dvd_neg   <= 1'b0;
         div0      <= 1'b0;
         hi        <= '0;
         lo        <= '0;
         busy      <= 1'b0;
         mult_done <= 1'b0;
         div_done  <= 1'b0;
`ifdef MULT_DIV_DIV0_FLAG_EN
         div_zero  <= 1'b0;
`endif
      end else begin
         mult_done <= 1'b0;
         div_done  <= 1'b0;
         case (state)
            IDLE: begin
               if (mult_start || div_start) begin
                  // Multiply wins when both starts arrive together.
                  is_mul  <= mult_start;
                  acc     <= {{WIDTH{1'b0}}, (mult_start ? mag_b : mag_a)};
                  opnd    <= mult_start ? mag_a : mag_b;
                  res_neg <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
                  dvd_neg <= ~mult_start & op_a[WIDTH-1];
                  div0    <= 1'b0;
                  cnt     <= '0;
                  busy    <= 1'b1;
                  state   <= mult_start ? MUL : DIV;
`ifdef MULT_DIV_DIV0_FLAG_EN
                  div_zero <= 1'b0;
`endif
               end
            end
            MUL: begin
               acc <= mul_next;
               cnt <= cnt + CW'(1);
               if (cnt == CW'(WIDTH-1)) state <= FIX;
            end
            DIV: begin
               if (opnd == '0) begin
                  // Remainder slot keeps |dividend| so sign fixing restores op_a.
                  acc   <= {acc[WIDTH-1:0], {WIDTH{DIV0_Q_BIT}}};
                  div0  <= 1'b1;
                  state <= FIX;
               end else begin
                  acc <= div_next;
                  cnt <= cnt + CW'(1);
                  if (cnt == CW'(WIDTH-1)) state <= FIX;
               end
            end
            FIX: begin
               if (is_mul) begin
                  {hi, lo}  <= prod_fix;
                  mult_done <= 1'b1;
               end else begin
                  hi       <= rem_fix;
                  lo       <= quo_fix;
                  div_done <= 1'b1;
`ifdef MULT_DIV_DIV0_FLAG_EN
                  div_zero <= div0;
`endif
               end
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
